uart_rx: RTL

//  UART receiver, 8N1, LSB first; the receive counterpart of the uart_clk_gen/tx_block transmit path.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, LSB first.
// Two-flop input synchroniser, private tick divider, mid-bit sampling, one-clock strobes.
module uart_rx #(
    parameter int CLK_FREQ  = 44,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int OS_COUNT = int'((CLK_FREQ * 1000000) / (BAUD_RATE * 16));
    localparam int OS_W     = (OS_COUNT > 1) ? $clog2(OS_COUNT) : 1;
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OS_COUNT - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
    logic [3:0]             os_cnt16_q, os_cnt16_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   armed_q, armed_d;
    logic                   tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            os_cnt_q    <= '0;
            os_cnt16_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            os_cnt_q    <= os_cnt_d;
            os_cnt16_q  <= os_cnt16_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        armed_d     = armed_q;

        tick       = (os_cnt_q == OS_LAST);
        os_cnt_d   = tick ? '0 : os_cnt_q + OS_W'(1);
        os_cnt16_d = tick ? os_cnt16_q + 4'd1 : os_cnt16_q;

        unique case (state_q)
            IDLE: begin
                // armed blocks retriggering on a line still low after a framing error
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = START;
                    os_cnt_d   = '0;
                    os_cnt16_d = '0;
                end
            end
            START: begin
                if (tick && os_cnt16_q == 4'd7) begin
                    if (!rx_s_q) begin
                        state_d    = DATA;
                        bit_idx_d  = '0;
                        os_cnt16_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && os_cnt16_q == 4'd15) begin
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick && os_cnt16_q == 4'd15) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
